// File: rtl/apa102_in.sv
// APA102 two-wire stream receiver: oversamples clock_in/data_in, finds start frames, decodes LED words.
// Optional mid-frame idle abort is compiled in with `define APA102_IN_TIMEOUT_EN.
module apa102_in #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clock_in,
   input  logic        data_in,
   output logic        pixel_valid,
   output logic [15:0] pixel_index,
   output logic [4:0]  pixel_brightness,
   output logic [7:0]  pixel_blue,
   output logic [7:0]  pixel_green,
   output logic [7:0]  pixel_red,
   output logic        frame_done,
   output logic [15:0] frame_pixel_count,
   output logic        frame_error,
   output logic        busy
);

   typedef enum logic {HUNT, FRAME} state_t;

   state_t      state_q, state_d;
   logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
   logic        dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic        rise_q, rise_d, bit_q, bit_d;
   logic [5:0]  zero_cnt_q, zero_cnt_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [30:0] shift_q, shift_d;
   logic [15:0] pixel_cnt_q, pixel_cnt_d;
   logic        pixel_valid_q, pixel_valid_d;
   logic [15:0] pixel_index_q, pixel_index_d;
   logic [4:0]  bright_q, bright_d;
   logic [7:0]  blue_q, blue_d, green_q, green_d, red_q, red_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        frame_error_q, frame_error_d;
   logic [31:0] word;
`ifdef APA102_IN_TIMEOUT_EN
   logic [31:0] idle_cnt_q, idle_cnt_d;
`endif

   always_comb begin
      state_d       = state_q;
      clk_s1_d      = clock_in;
      clk_s2_d      = clk_s1_q;
      clk_s3_d      = clk_s2_q;
      dat_s1_d      = data_in;
      dat_s2_d      = dat_s1_q;
      // Edge and data sample are registered together so a processed bit lags the pin by 3 clk.
      rise_d        = clk_s2_q & ~clk_s3_q;
      bit_d         = (clk_s2_q & ~clk_s3_q) ? dat_s2_q : bit_q;
      zero_cnt_d    = zero_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      pixel_cnt_d   = pixel_cnt_q;
      pixel_valid_d = 1'b0;
      pixel_index_d = pixel_index_q;
      bright_d      = bright_q;
      blue_d        = blue_q;
      green_d       = green_q;
      red_d         = red_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      frame_error_d = 1'b0;
      word          = {shift_q, bit_q};
`ifdef APA102_IN_TIMEOUT_EN
      idle_cnt_d    = '0;
`endif

      case (state_q)
         HUNT: begin
            if (rise_q) begin
               if (!bit_q) begin
                  if (zero_cnt_q != 6'd32) zero_cnt_d = zero_cnt_q + 6'd1;
               end else if (zero_cnt_q == 6'd32) begin
                  // This 1 is already bit 31 of the first word.
                  state_d       = FRAME;
                  zero_cnt_d    = '0;
                  bit_cnt_d     = 5'd1;
                  shift_d       = 31'd1;
                  pixel_cnt_d   = '0;
                  pixel_index_d = '0;
               end else begin
                  zero_cnt_d = '0;
               end
            end
         end
         FRAME: begin
            if (rise_q) begin
               shift_d   = word[30:0];
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'd31) begin
                  if (word == '1) begin
                     frame_done_d  = 1'b1;
                     frame_count_d = pixel_cnt_q;
                     state_d       = HUNT;
                     zero_cnt_d    = '0;
                  end else if (word[31:29] == 3'b111) begin
                     pixel_valid_d = 1'b1;
                     pixel_index_d = pixel_cnt_q;
                     bright_d      = word[28:24];
                     blue_d        = word[23:16];
                     green_d       = word[15:8];
                     red_d         = word[7:0];
                     pixel_cnt_d   = pixel_cnt_q + 16'd1;
                  end else if (word == '0) begin
                     pixel_cnt_d = '0;
                  end else begin
                     frame_error_d = 1'b1;
                     state_d       = HUNT;
                     zero_cnt_d    = '0;
                  end
               end
            end
`ifdef APA102_IN_TIMEOUT_EN
            else if (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               frame_error_d = 1'b1;
               state_d       = HUNT;
               zero_cnt_d    = '0;
               bit_cnt_d     = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 32'd1;
            end
`endif
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         clk_s1_q      <= 1'b0;
         clk_s2_q      <= 1'b0;
         clk_s3_q      <= 1'b0;
         dat_s1_q      <= 1'b0;
         dat_s2_q      <= 1'b0;
         rise_q        <= 1'b0;
         bit_q         <= 1'b0;
         zero_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         pixel_cnt_q   <= '0;
         pixel_valid_q <= 1'b0;
         pixel_index_q <= '0;
         bright_q      <= '0;
         blue_q        <= '0;
         green_q       <= '0;
         red_q         <= '0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         frame_error_q <= 1'b0;
`ifdef APA102_IN_TIMEOUT_EN
         idle_cnt_q    <= '0;
`endif
      end else begin
         state_q       <= state_d;
         clk_s1_q      <= clk_s1_d;
         clk_s2_q      <= clk_s2_d;
         clk_s3_q      <= clk_s3_d;
         dat_s1_q      <= dat_s1_d;
         dat_s2_q      <= dat_s2_d;
         rise_q        <= rise_d;
         bit_q         <= bit_d;
         zero_cnt_q    <= zero_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         pixel_cnt_q   <= pixel_cnt_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_index_q <= pixel_index_d;
         bright_q      <= bright_d;
         blue_q        <= blue_d;
         green_q       <= green_d;
         red_q         <= red_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         frame_error_q <= frame_error_d;
`ifdef APA102_IN_TIMEOUT_EN
         idle_cnt_q    <= idle_cnt_d;
`endif
      end
   end

   assign pixel_valid       = pixel_valid_q;
   assign pixel_index       = pixel_index_q;
   assign pixel_brightness  = bright_q;
   assign pixel_blue        = blue_q;
   assign pixel_green       = green_q;
   assign pixel_red         = red_q;
   assign frame_done        = frame_done_q;
   assign frame_pixel_count = frame_count_q;
   assign frame_error       = frame_error_q;
   assign busy              = (state_q == FRAME);

endmodule

// File: tb/tb_apa102_in.sv
// Directed bench for apa102_in: bit-banged APA102 words, strobe monitor queue, hand-computed expectations.
module tb_apa102_in;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clock_in = 1'b0;
   logic        data_in = 1'b0;
   logic        pixel_valid;
   logic [15:0] pixel_index;
   logic [4:0]  pixel_brightness;
   logic [7:0]  pixel_blue, pixel_green, pixel_red;
   logic        frame_done;
   logic [15:0] frame_pixel_count;
   logic        frame_error;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rise_cyc = 0;

   typedef struct {
      int          kind;  // 0 pixel, 1 done, 2 error
      logic [15:0] idx;
      logic [4:0]  br;
      logic [7:0]  b, g, r;
      logic [15:0] cnt;
      int          lat;
   } evt_t;

   evt_t evq[$];

   apa102_in #(.TIMEOUT_CYCLES(64)) dut (
      .clk               (clk),
      .rst               (rst),
      .clock_in          (clock_in),
      .data_in           (data_in),
      .pixel_valid       (pixel_valid),
      .pixel_index       (pixel_index),
      .pixel_brightness  (pixel_brightness),
      .pixel_blue        (pixel_blue),
      .pixel_green       (pixel_green),
      .pixel_red         (pixel_red),
      .frame_done        (frame_done),
      .frame_pixel_count (frame_pixel_count),
      .frame_error       (frame_error),
      .busy              (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         int n;
         evt_t e;
         n = int'(pixel_valid) + int'(frame_done) + int'(frame_error);
         if (n != 0) begin
            check("one_strobe", n, 1);
            e.kind = pixel_valid ? 0 : (frame_done ? 1 : 2);
            e.idx  = pixel_index;
            e.br   = pixel_brightness;
            e.b    = pixel_blue;
            e.g    = pixel_green;
            e.r    = pixel_red;
            e.cnt  = frame_pixel_count;
            e.lat  = cyc - rise_cyc;
            evq.push_back(e);
         end
      end
   end

   task automatic send_bit(input logic b);
      @(negedge clk) data_in = b;
      repeat (2) @(negedge clk);
      clock_in = 1'b1;
      rise_cyc = cyc;
      repeat (3) @(negedge clk);
      clock_in = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_fill(input int n, input logic b);
      for (int i = 0; i < n; i++) send_bit(b);
   endtask

   task automatic settle();
      repeat (8) @(negedge clk);
   endtask

   task automatic pop_evt(input string tag, output evt_t e, output bit ok);
      check(tag, 32'(evq.size() != 0), 1);
      ok = (evq.size() != 0);
      if (ok) e = evq.pop_front();
   endtask

   task automatic expect_pixel(input string tag, input logic [15:0] idx, input logic [31:0] w);
      evt_t e;
      bit ok;
      pop_evt({tag, "_present"}, e, ok);
      if (ok) begin
         check({tag, "_kind"}, e.kind, 0);
         check({tag, "_index"}, e.idx, idx);
         check({tag, "_bright"}, e.br, w[28:24]);
         check({tag, "_blue"}, e.b, w[23:16]);
         check({tag, "_green"}, e.g, w[15:8]);
         check({tag, "_red"}, e.r, w[7:0]);
         check({tag, "_latency"}, e.lat, 4);
      end
   endtask

   task automatic expect_done(input string tag, input logic [15:0] cnt);
      evt_t e;
      bit ok;
      pop_evt({tag, "_present"}, e, ok);
      if (ok) begin
         check({tag, "_kind"}, e.kind, 1);
         check({tag, "_count"}, e.cnt, cnt);
         check({tag, "_latency"}, e.lat, 4);
      end
   endtask

   task automatic expect_none(input string tag);
      check(tag, evq.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_strobes"}, {pixel_valid, frame_done, frame_error}, 0);
      check({tag, "_index"}, pixel_index, 0);
      check({tag, "_fields"}, {pixel_brightness, pixel_blue, pixel_green, pixel_red}, 0);
      check({tag, "_count"}, frame_pixel_count, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      evt_t e;
      bit ok;
      repeat (4) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // 31 zeros are not a start frame
      send_fill(31, 1'b0);
      send_word(32'hE100_0000);
      send_fill(32, 1'b1);
      settle();
      expect_none("short_start_no_evt");
      check("short_start_busy", busy, 0);

      // two pixels then end frame
      send_fill(32, 1'b0);
      send_word(32'hE501_0203);
      settle();
      check("t1_busy", busy, 1);
      send_word(32'hFF10_2030);
      send_fill(32, 1'b1);
      settle();
      expect_pixel("t1_p0", 16'd0, 32'hE501_0203);
      expect_pixel("t1_p1", 16'd1, 32'hFF10_2030);
      expect_done("t1_done", 16'd2);
      check("t1_busy_after", busy, 0);
      check("t1_count_held", frame_pixel_count, 2);

      // extra leading zeros tolerated
      send_fill(40, 1'b0);
      send_word(32'hE0FF_FFFF);
      settle();
      expect_pixel("t2_p0", 16'd0, 32'hE0FF_FFFF);
      expect_none("t2_single");

      // malformed word mid-frame
      send_word(32'h4000_0000);
      settle();
      pop_evt("t3_err_present", e, ok);
      if (ok) begin
         check("t3_err_kind", e.kind, 2);
         check("t3_err_latency", e.lat, 4);
      end
      check("t3_busy_fell", busy, 0);
      send_fill(32, 1'b0);
      send_word(32'hE7AB_CDEF);
      send_fill(32, 1'b1);
      settle();
      expect_pixel("t3_p0", 16'd0, 32'hE7AB_CDEF);
      expect_done("t3_done", 16'd1);

      // all-zero word restarts pixel numbering
      send_fill(32, 1'b0);
      send_word(32'hE100_0000);
      send_fill(32, 1'b0);
      send_word(32'hE200_0000);
      send_fill(32, 1'b1);
      settle();
      expect_pixel("t4_p0", 16'd0, 32'hE100_0000);
      expect_pixel("t4_p0_again", 16'd0, 32'hE200_0000);
      expect_done("t4_done", 16'd1);

      // reset mid-word
      send_fill(32, 1'b0);
      for (int i = 0; i < 17; i++) send_bit(1'b1);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("t5_rst");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("t5_after");
      expect_none("t5_no_evt");
      send_fill(32, 1'b0);
      send_word(32'hE3AA_BBCC);
      send_fill(32, 1'b1);
      settle();
      expect_pixel("t5_p0", 16'd0, 32'hE3AA_BBCC);
      expect_done("t5_done", 16'd1);

      // clock_in stops after 10 bits
      send_fill(32, 1'b0);
      for (int i = 0; i < 10; i++) send_bit(1'b1);
`ifdef APA102_IN_TIMEOUT_EN
      for (int i = 0; i < 300 && evq.size() == 0; i++) @(negedge clk);
      pop_evt("t6_timeout_present", e, ok);
      if (ok) begin
         check("t6_timeout_kind", e.kind, 2);
         check("t6_timeout_window", 32'(e.lat >= 64 && e.lat <= 72), 1);
      end
      settle();
      expect_none("t6_single");
      check("t6_busy", busy, 0);
`else
      repeat (10000) @(negedge clk);
      expect_none("t6_no_timeout");
      check("t6_busy_held", busy, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/apa102_in.md
# apa102_in

APA102 serial stream receiver: the sink for the two-wire data/clock stream driven by the APA102 output block. It oversamples `clock_in`/`data_in` on the system clock and locates start frames. It decodes each 32-bit LED frame into brightness and RGB fields and reports end-of-frame with a pixel count. Used for loopback verification of the POV output path and for chaining boards.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: idle `clk` cycles mid-frame before abort (only with `APA102_IN_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; all logic on rising edge; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `clock_in`  in  1  APA102 clock line (asynchronous to `clk`).
- `data_in`  in  1  APA102 data line (asynchronous to `clk`).
- `pixel_valid`  out  1  one-cycle strobe: pixel fields valid.
- `pixel_index`  out  16  index of the pixel within the current frame, 0-based.
- `pixel_brightness`  out  5  global brightness field.
- `pixel_blue`, `pixel_green`, `pixel_red`  out  8 each  colour bytes.
- `frame_done`  out  1  one-cycle strobe: end frame received.
- `frame_pixel_count`  out  16  pixels in the completed frame; valid with `frame_done`, held after.
- `frame_error`  out  1  one-cycle strobe: malformed word (or timeout).
- `busy`  out  1  high while in FRAME state.

## Operation
- `clock_in` and `data_in` each pass through an identical 2-flop synchronizer. A third register on synchronized `clock_in` provides rising-edge detect. `data_in` is sampled, from the same synchronizer stage, on a detected rising edge.
- Bits arrive MSB first. A 32-bit word has the layout `[31:29]` header `111`, `[28:24]` brightness, `[23:16]` blue, `[15:8]` green, `[7:0]` red.
- States:
  - HUNT (reset state): a 6-bit zero counter counts consecutive sampled 0 bits and saturates at 32. A sampled 1 with the counter below 32 clears the counter. A sampled 1 with the counter at 32 enters FRAME; that bit is bit 31 of the first word, and `pixel_index` clears to 0. Extra zeros beyond 32 are therefore tolerated.
  - FRAME: shifts bits in; a 5-bit bit counter drives completion. On the 32nd bit the word is classified:
    - All ones: end frame. Pulse `frame_done`, load `frame_pixel_count` from the pixel counter, go to HUNT with the zero counter at 0. This is checked before the LED-frame test, so a full-brightness white pixel (0xFFFFFFFF) always terminates the frame.
    - Header `111`, not all ones: LED frame. Pulse `pixel_valid` with the fields. Increment the pixel counter; it wraps 0xFFFF to 0x0000 with no flag.
    - All zeros: restart. Stay in FRAME with the pixel counter at 0, and treat the next word as pixel 0. No strobe.
    - Any other value: pulse `frame_error`, go to HUNT with the zero counter at 0.
- At most one of `pixel_valid` / `frame_done` / `frame_error` is asserted in any cycle.
- Pixel fields and `pixel_index` hold their last values between strobes.

## Timing
- Strobe latency: a strobe is high exactly 3 `clk` cycles after the first `clk` edge at which the 32nd `clock_in` high level is present at the pin. It is high for exactly 1 cycle.
- Input constraint: each `clock_in` high and low phase lasts at least 3 `clk` cycles. `data_in` is stable from 2 cycles before to 2 cycles after the `clock_in` rising edge. Faster input is undefined behaviour.
- Reset:
  - Outputs are all 0: strobes, fields, `pixel_index`, `frame_pixel_count`, `busy`.
  - Synchronizers, shift register and counters clear; state goes to HUNT.
  - Reset mid-word discards the partial word with no strobe.
  - After reset is released, a full 32-zero start frame is needed before decoding.

## Configuration
- `APA102_IN_TIMEOUT_EN` defined: in FRAME, an idle counter clears on every detected `clock_in` rising edge. If it reaches `TIMEOUT_CYCLES` with no edge, the block discards the partial word, pulses `frame_error` once, and goes to HUNT with the zero counter at 0.
- Macro undefined: no idle counter; FRAME waits indefinitely for the next edge.

## Test plan
- 32 zeros, then words 0xE5010203 and 0xFF102030, then 32 ones:
  - First strobe: `pixel_valid` with index 0, brightness 5, B=0x01, G=0x02, R=0x03.
  - Second strobe: index 1, brightness 31, B=0x10, G=0x20, R=0x30.
  - Then `frame_done` with `frame_pixel_count` = 2.
- 40 zeros, then 0xE0FFFFFF -> exactly one `pixel_valid`, index 0, brightness 0, B=G=R=0xFF.
- Start frame, one pixel, then word 0x40000000 -> `frame_error` 1 cycle, `busy` falls. A following start frame + pixel reports index 0.
- Start frame, 0xE1000000, then 32 zeros, then 0xE2000000 -> the second pixel reports index 0, brightness 2.
- Assert `rst` after 17 bits of a word -> no strobe, all outputs 0. The next full frame decodes correctly.
- With `APA102_IN_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64: stop `clock_in` after 10 bits -> one `frame_error` 64 cycles after the last edge. Without the macro, no strobe within 10000 cycles.
